// File: rtl/rv_ctl_mc.sv
// Multi-cycle RV32 subset control unit: sequences fetch, decode, memory
// access, ALU and control-transfer steps. It also provides a per-access
// memory wait timeout, a sticky error state and a retired-instruction counter.
//
// state     | meaning
// ----------+----------------------------------------------------------
// FETCH     | request instruction word, load IR and PC+4 on mem_ready
// DECODE    | precompute branch target, dispatch on opcode/funct3
// MEM_ADDR  | form load/store effective address rs1 + imm
// LOAD_MEM  | read data memory, capture MDR on mem_ready
// LOAD_WB   | write MDR to rd
// STORE_MEM | write data memory until mem_ready
// EXEC      | register/immediate ALU operation or LUI
// ALU_WB    | write ALUOUT to rd
// BRANCH    | compare rs1/rs2, conditionally load branch target
// JAL_EX    | PC <- PC + J-imm, rd <- PC+4
// JALR_EX   | PC <- (rs1 + I-imm) & ~1, rd <- PC+4
// ERROR     | illegal instruction or memory timeout, held until reset
module rv_ctl_mc #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int TRAP_ILLEGAL = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       pcsrc,
    output logic             pcwrite,
    output logic             pccen,
    output logic             irwrite,
    output logic             mdrwrite,
    output logic             regwen,
    output logic [1:0]       wbsel,
    output logic [2:0]       immsel,
    output logic [1:0]       asel,
    output logic             bsel,
    output logic [3:0]       alusel,
    output logic             err,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, LOAD_MEM, LOAD_WB, STORE_MEM,
        EXEC, ALU_WB, BRANCH, JAL_EX, JALR_EX, ERROR
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;

    // Counter only needs to reach MEM_TIMEOUT-1: the timeout fires on that cycle.
    localparam int WCNT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    state_t            state, state_nx;
    logic [WCNT_W-1:0] wait_cnt;
    logic              mem_timeout;
    logic              waiting;
    logic              retire;
    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic              unused_instr_bits;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    // Instruction fields the controller never looks at.
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign waiting     = (state == FETCH) || (state == LOAD_MEM) || (state == STORE_MEM);
    assign mem_timeout = (MEM_TIMEOUT > 0) && (wait_cnt == WCNT_W'(TO_LAST));
    assign retire      = (state_nx == FETCH) &&
                         ((state == LOAD_WB) || (state == STORE_MEM) || (state == ALU_WB) ||
                          (state == BRANCH)  || (state == JAL_EX)    || (state == JALR_EX));
    assign err         = (state == ERROR);

    // State register; reset aborts whatever access is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nx;
    end

    // Wait counter: runs while a memory state stalls, zero otherwise, so every
    // entry into a memory state starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        wait_cnt <= '0;
        else if (waiting && !mem_ready) wait_cnt <= wait_cnt + WCNT_W'(1);
        else                            wait_cnt <= '0;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         instret <= '0;
        else if (retire) instret <= instret + CNT_W'(1);
    end

    // Next-state and control outputs.
    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        pcsrc    = 2'd0;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        mdrwrite = 1'b0;
        regwen   = 1'b0;
        wbsel    = 2'd0;
        immsel   = 3'd0;
        asel     = 2'd0;
        bsel     = 1'b0;
        alusel   = ALU_ADD;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    irwrite  = 1'b1;
                    pcwrite  = 1'b1;
                    pccen    = 1'b1;
                    state_nx = DECODE;
                end else if (mem_timeout) begin
                    state_nx = ERROR;
                end
            end
            DECODE: begin
                immsel   = 3'd2;
                asel     = 2'd1;
                bsel     = 1'b1;
                state_nx = (TRAP_ILLEGAL != 0) ? ERROR : FETCH;
                case (opcode)
                    OPC_LOAD, OPC_STORE: if (f3 == 3'b010) state_nx = MEM_ADDR;
                    OPC_OP_IMM, OPC_OP, OPC_LUI: state_nx = EXEC;
                    OPC_BRANCH: if (f3 == 3'b000 || f3 == 3'b001) state_nx = BRANCH;
                    OPC_JAL: state_nx = JAL_EX;
                    OPC_JALR: if (f3 == 3'b000) state_nx = JALR_EX;
                    default: ;
                endcase
            end
            MEM_ADDR: begin
                bsel = 1'b1;
                if (opcode == OPC_STORE) begin
                    immsel   = 3'd1;
                    state_nx = STORE_MEM;
                end else begin
                    state_nx = LOAD_MEM;
                end
            end
            LOAD_MEM: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    mdrwrite = 1'b1;
                    state_nx = LOAD_WB;
                end else if (mem_timeout) begin
                    state_nx = ERROR;
                end
            end
            LOAD_WB: begin
                regwen   = 1'b1;
                wbsel    = 2'd2;
                state_nx = FETCH;
            end
            STORE_MEM: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready)        state_nx = FETCH;
                else if (mem_timeout) state_nx = ERROR;
            end
            EXEC: begin
                state_nx = ALU_WB;
                case (opcode)
                    OPC_OP: alusel = {f3, instr[30]};
                    OPC_OP_IMM: begin
                        bsel   = 1'b1;
                        alusel = {f3, (f3 == 3'b101) ? instr[30] : 1'b0};
                    end
                    OPC_LUI: begin
                        asel   = 2'd2;
                        bsel   = 1'b1;
                        immsel = 3'd4;
                    end
                    default: ;
                endcase
            end
            ALU_WB: begin
                regwen   = 1'b1;
                wbsel    = 2'd1;
                state_nx = FETCH;
            end
            BRANCH: begin
                alusel   = ALU_SUB;
                pcsrc    = 2'd1;
                pcwrite  = (f3 == 3'b000) ? zero : !zero;
                state_nx = FETCH;
            end
            JAL_EX: begin
                immsel   = 3'd3;
                asel     = 2'd1;
                bsel     = 1'b1;
                pcsrc    = 2'd1;
                pcwrite  = 1'b1;
                regwen   = 1'b1;
                state_nx = FETCH;
            end
            JALR_EX: begin
                bsel     = 1'b1;
                pcsrc    = 2'd2;
                pcwrite  = 1'b1;
                regwen   = 1'b1;
                state_nx = FETCH;
            end
            ERROR: state_nx = ERROR;
            default: state_nx = ERROR;
        endcase
        // Reset holds the state in FETCH; keep the bus and enables quiet meanwhile.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            pcwrite = 1'b0;
            pccen   = 1'b0;
            irwrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_ctl_mc.sv
// Testbench for rv_ctl_mc. Two instances share all stimulus:
// A uses the default parameters, B has TRAP_ILLEGAL=0 and a 4-bit instret.
module tb_rv_ctl_mc;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       pccen;
        logic       irwrite;
        logic       mdrwrite;
        logic       regwen;
        logic [1:0] wbsel;
        logic [2:0] immsel;
        logic [1:0] asel;
        logic       bsel;
        logic [3:0] alusel;
        logic       err;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        out_t        exp3;
        int          n_more;
    } vec_t;

    logic clk, rst, zero, mem_ready;
    logic [31:0] instr;

    logic a_mem_req, a_mem_we, a_pcwrite, a_pccen, a_irwrite, a_mdrwrite, a_regwen, a_bsel, a_err;
    logic [1:0] a_pcsrc, a_wbsel, a_asel;
    logic [2:0] a_immsel;
    logic [3:0] a_alusel;
    logic [31:0] instret_a;
    logic b_mem_req, b_mem_we, b_pcwrite, b_pccen, b_irwrite, b_mdrwrite, b_regwen, b_bsel, b_err;
    logic [1:0] b_pcsrc, b_wbsel, b_asel;
    logic [2:0] b_immsel;
    logic [3:0] b_alusel;
    logic [3:0] instret_b;

    out_t obs_a, obs_b;
    assign obs_a = {a_mem_req, a_mem_we, a_pcsrc, a_pcwrite, a_pccen, a_irwrite, a_mdrwrite,
                    a_regwen, a_wbsel, a_immsel, a_asel, a_bsel, a_alusel, a_err};
    assign obs_b = {b_mem_req, b_mem_we, b_pcsrc, b_pcwrite, b_pccen, b_irwrite, b_mdrwrite,
                    b_regwen, b_wbsel, b_immsel, b_asel, b_bsel, b_alusel, b_err};

    rv_ctl_mc #(.MEM_TIMEOUT(16), .TRAP_ILLEGAL(1), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .pcsrc(a_pcsrc), .pcwrite(a_pcwrite),
        .pccen(a_pccen), .irwrite(a_irwrite), .mdrwrite(a_mdrwrite), .regwen(a_regwen),
        .wbsel(a_wbsel), .immsel(a_immsel), .asel(a_asel), .bsel(a_bsel),
        .alusel(a_alusel), .err(a_err), .instret(instret_a)
    );

    rv_ctl_mc #(.MEM_TIMEOUT(16), .TRAP_ILLEGAL(0), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .pcsrc(b_pcsrc), .pcwrite(b_pcwrite),
        .pccen(b_pccen), .irwrite(b_irwrite), .mdrwrite(b_mdrwrite), .regwen(b_regwen),
        .wbsel(b_wbsel), .immsel(b_immsel), .asel(b_asel), .bsel(b_bsel),
        .alusel(b_alusel), .err(b_err), .instret(instret_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_ret = '0;

    localparam logic [31:0] I_LW  = 32'h00412083;
    localparam logic [31:0] I_SW  = 32'h00112223;
    localparam logic [31:0] I_JAL = 32'h008000EF;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic out_t o3(input logic [1:0] pcsrc, input logic pcwrite, input logic regwen,
                                input logic [1:0] wbsel, input logic [2:0] immsel,
                                input logic [1:0] asel, input logic bsel, input logic [3:0] alusel);
        out_t e = '0;
        e.pcsrc = pcsrc; e.pcwrite = pcwrite; e.regwen = regwen; e.wbsel = wbsel;
        e.immsel = immsel; e.asel = asel; e.bsel = bsel; e.alusel = alusel;
        return e;
    endfunction

    function automatic out_t e_fetch(input logic rdy);
        out_t e = '0;
        e.mem_req = 1'b1;
        if (rdy) begin
            e.irwrite = 1'b1; e.pcwrite = 1'b1; e.pccen = 1'b1;
        end
        return e;
    endfunction

    function automatic out_t e_decode();
        return o3(2'd0, 1'b0, 1'b0, 2'd0, 3'd2, 2'd1, 1'b1, 4'd0);
    endfunction

    function automatic out_t e_err();
        out_t e = '0;
        e.err = 1'b1;
        return e;
    endfunction

    function automatic out_t e_mem(input logic we, input logic mdr);
        out_t e = '0;
        e.mem_req = 1'b1; e.mem_we = we; e.mdrwrite = mdr;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // One clock cycle: drive inputs after the falling edge, sample 1 ns later.
    task automatic cyc(input logic rdy, input logic z, input out_t ea, input out_t eb, input string nm);
        @(negedge clk);
        mem_ready = rdy;
        zero = z;
        #1;
        chk({nm, " A"}, 64'(obs_a), 64'(ea));
        chk({nm, " B"}, 64'(obs_b), 64'(eb));
        chk({nm, " instret A"}, 64'(instret_a), 64'(exp_ret));
        chk({nm, " instret B"}, 64'(instret_b), 64'(exp_ret[3:0]));
    endtask

    task automatic c1(input logic rdy, input logic z, input out_t e, input string nm);
        cyc(rdy, z, e, e, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        exp_ret = '0;
        for (int i = 0; i < 2; i++) begin
            chk("rst outputs A", 64'(obs_a), 64'(0));
            chk("rst outputs B", 64'(obs_b), 64'(0));
            chk("rst instret A", 64'(instret_a), 64'(0));
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Instruction-level reference: expected per-cycle outputs from fetch to retire.
    task automatic run_instr(input logic [31:0] ins, input int fd, input int md);
        logic [6:0] op;
        logic [2:0] f3;
        logic z;
        op = ins[6:0];
        f3 = ins[14:12];
        instr = ins;
        for (int i = 0; i < fd; i++) c1(1'b0, rb(), e_fetch(1'b0), "fetch_wait");
        c1(1'b1, rb(), e_fetch(1'b1), "fetch_done");
        c1(rb(), rb(), e_decode(), "decode");
        if ((op == 7'b0000011 || op == 7'b0100011) && f3 == 3'b010) begin
            c1(rb(), rb(), o3(0, 0, 0, 0, (op == 7'b0100011) ? 3'd1 : 3'd0, 0, 1, 0), "mem_addr");
            for (int i = 0; i < md; i++) c1(1'b0, rb(), e_mem(op[5], 1'b0), "mem_wait");
            c1(1'b1, rb(), e_mem(op[5], !op[5]), "mem_done");
            if (!op[5]) c1(rb(), rb(), o3(0, 0, 1, 2, 0, 0, 0, 0), "load_wb");
        end else if (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0110111) begin
            if (op == 7'b0110011)
                c1(rb(), rb(), o3(0, 0, 0, 0, 0, 0, 0, {f3, ins[30]}), "op_exec");
            else if (op == 7'b0010011)
                c1(rb(), rb(), o3(0, 0, 0, 0, 0, 0, 1, {f3, (f3 == 3'b101) ? ins[30] : 1'b0}), "opimm_exec");
            else
                c1(rb(), rb(), o3(0, 0, 0, 0, 4, 2, 1, 0), "lui_exec");
            c1(rb(), rb(), o3(0, 0, 1, 1, 0, 0, 0, 0), "alu_wb");
        end else if (op == 7'b1100011) begin
            z = rb();
            c1(rb(), z, o3(1, (f3 == 3'b000) ? z : !z, 0, 0, 0, 0, 0, 4'b0001), "branch");
        end else if (op == 7'b1101111) begin
            c1(rb(), rb(), o3(1, 1, 1, 0, 3, 1, 1, 0), "jal");
        end else begin
            c1(rb(), rb(), o3(2, 1, 1, 0, 0, 0, 1, 0), "jalr");
        end
        exp_ret++;
    endtask

    function automatic logic [31:0] gen(input int c);
        logic [31:0] r;
        r = $urandom;
        case (c)
            0: begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
            1: begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
            2: r[6:0] = 7'b0010011;
            3: r[6:0] = 7'b0110011;
            4: r[6:0] = 7'b0110111;
            5: begin r[6:0] = 7'b1100011; r[14:13] = 2'b00; end
            6: r[6:0] = 7'b1101111;
            default: begin r[6:0] = 7'b1100111; r[14:12] = 3'b000; end
        endcase
        return r;
    endfunction

    task automatic illegal_seq(input logic [31:0] ins);
        do_reset();
        instr = ins;
        c1(1'b1, 1'b0, e_fetch(1'b1), "ill_fetch");
        c1(1'b0, 1'b0, e_decode(), "ill_decode");
        cyc(1'b0, 1'b0, e_err(), e_fetch(1'b0), "ill_after");
        cyc(1'b0, 1'b1, e_err(), e_fetch(1'b0), "ill_after2");
    endtask

    vec_t tbl[17];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'h00412083, 1'b0, o3(0, 0, 0, 0, 0, 0, 1, 4'b0000), 2};
        tbl[1]  = '{32'h00112223, 1'b0, o3(0, 0, 0, 0, 1, 0, 1, 4'b0000), 1};
        tbl[2]  = '{32'h00209463, 1'b1, o3(1, 0, 0, 0, 0, 0, 0, 4'b0001), 0};
        tbl[3]  = '{32'h00209463, 1'b0, o3(1, 1, 0, 0, 0, 0, 0, 4'b0001), 0};
        tbl[4]  = '{32'h00208463, 1'b1, o3(1, 1, 0, 0, 0, 0, 0, 4'b0001), 0};
        tbl[5]  = '{32'h00208463, 1'b0, o3(1, 0, 0, 0, 0, 0, 0, 4'b0001), 0};
        tbl[6]  = '{32'h4020D093, 1'b0, o3(0, 0, 0, 0, 0, 0, 1, 4'b1011), 1};
        tbl[7]  = '{32'h00209093, 1'b0, o3(0, 0, 0, 0, 0, 0, 1, 4'b0010), 1};
        tbl[8]  = '{32'h40008093, 1'b0, o3(0, 0, 0, 0, 0, 0, 1, 4'b0000), 1};
        tbl[9]  = '{32'h402081B3, 1'b0, o3(0, 0, 0, 0, 0, 0, 0, 4'b0001), 1};
        tbl[10] = '{32'h4020D1B3, 1'b0, o3(0, 0, 0, 0, 0, 0, 0, 4'b1011), 1};
        tbl[11] = '{32'h123450B7, 1'b0, o3(0, 0, 0, 0, 4, 2, 1, 4'b0000), 1};
        tbl[12] = '{32'h008000EF, 1'b0, o3(1, 1, 1, 0, 3, 1, 1, 4'b0000), 0};
        tbl[13] = '{32'h000100E7, 1'b0, o3(2, 1, 1, 0, 0, 0, 1, 4'b0000), 0};
        tbl[14] = '{32'h0020D093, 1'b0, o3(0, 0, 0, 0, 0, 0, 1, 4'b1010), 1};
        tbl[15] = '{32'h4020A1B3, 1'b0, o3(0, 0, 0, 0, 0, 0, 0, 4'b0101), 1};
        tbl[16] = '{32'h4000A093, 1'b0, o3(0, 0, 0, 0, 0, 0, 1, 4'b0100), 1};

        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; instr = '0;
        do_reset();

        // Table of single instructions, memory always ready.
        for (int i = 0; i < 17; i++) begin
            instr = tbl[i].instr;
            c1(1'b1, rb(), e_fetch(1'b1), "tbl_fetch");
            c1(rb(), rb(), e_decode(), "tbl_decode");
            c1(1'b1, tbl[i].zero, tbl[i].exp3, $sformatf("tbl[%0d]", i));
            for (int j = 0; j < tbl[i].n_more; j++) begin
                @(negedge clk);
                mem_ready = 1'b1;
                zero = rb();
            end
            exp_ret++;
        end

        // Fetch with ready delayed by 3, then lw with immediate ready.
        run_instr(I_LW, 3, 0);
        run_instr(I_LW, 0, 0);

        // Asynchronous reset in the middle of a store access.
        instr = I_SW;
        c1(1'b1, rb(), e_fetch(1'b1), "abort_fetch");
        c1(rb(), rb(), e_decode(), "abort_decode");
        c1(rb(), rb(), o3(0, 0, 0, 0, 1, 0, 1, 0), "abort_addr");
        c1(1'b0, rb(), e_mem(1'b1, 1'b0), "abort_store");
        c1(1'b0, rb(), e_mem(1'b1, 1'b0), "abort_store");
        #1 rst = 1'b1;
        #1;
        chk("async rst outputs A", 64'(obs_a), 64'(0));
        chk("async rst instret A", 64'(instret_a), 64'(0));
        rst = 1'b0;
        #1;
        chk("async rst state A", 64'(obs_a), 64'(e_fetch(1'b0)));
        chk("async rst state B", 64'(obs_b), 64'(e_fetch(1'b0)));
        exp_ret = '0;
        run_instr(I_JAL, 0, 0);

        // Fetch timeout after 16 non-ready cycles; error is sticky until reset.
        do_reset();
        for (int i = 0; i < 16; i++) c1(1'b0, rb(), e_fetch(1'b0), "fetch_to_wait");
        for (int i = 0; i < 3; i++) c1(1'b1, rb(), e_err(), "fetch_to_err");

        // Store timeout after 16 non-ready cycles.
        do_reset();
        instr = I_SW;
        c1(1'b1, rb(), e_fetch(1'b1), "sto_fetch");
        c1(rb(), rb(), e_decode(), "sto_decode");
        c1(rb(), rb(), o3(0, 0, 0, 0, 1, 0, 1, 0), "sto_addr");
        for (int i = 0; i < 16; i++) c1(1'b0, rb(), e_mem(1'b1, 1'b0), "sto_wait");
        for (int i = 0; i < 4; i++) c1(1'b1, rb(), e_err(), "sto_err");

        // mem_ready on the cycle the timeout would fire wins.
        do_reset();
        run_instr(I_SW, 15, 15);
        run_instr(I_LW, 15, 15);

        // Illegal instructions: A traps, B treats them as NOPs.
        illegal_seq(32'h0000007F);
        illegal_seq(32'h00410083);
        illegal_seq(32'h0020C463);
        illegal_seq(32'h000110E7);

        // Randomized instruction stream against the instruction-level model.
        do_reset();
        for (int k = 0; k < 200; k++) begin
            int fd, md;
            fd = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4));
            md = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4));
            run_instr(gen(int'($urandom_range(0, 7))), fd, md);
        end
        c1(1'b0, rb(), e_fetch(1'b0), "final_fetch");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
